// File: rtl/dispatcher_pkg.sv
// dispatcher_pkg: constants and types shared across the dispatcher back end.
//   N_REQ / TAG_W / DATA_W : number of CDB requesters, rename tag width, result width
//   UNIT_*                 : requester index of each execution-unit queue on the CDB
//   cdb_t                  : one CDB broadcast, as seen by the RST, RS and register file
package dispatcher_pkg;

  localparam int N_REQ  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam int UNIT_INT = 0;
  localparam int UNIT_MUL = 1;
  localparam int UNIT_DIV = 2;
  localparam int UNIT_LS  = 3;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } cdb_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational N-bit rotate-priority picker.
//   req   : request vector
//   start : index that has highest priority; the search runs upward and wraps
//   gnt   : one-hot grant (all zero when req is zero)
//   idx   : encoded index of the granted bit (0 when nothing is granted)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int unsigned pos;
  logic        found;

  // NOTE: every output and temporary gets a default at the top of the block so
  // no path through the loop leaves a value unassigned, which would infer a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants the single Common Data Bus to one execution-unit queue per
// cycle and drives the registered broadcast consumed by the RST, RS and regfile.
//   clk, rst             : clock; asynchronous active-low reset
//   req_valid/tag/data   : per-unit completed result, unit i at slice i
//   flush                : suppress grant (and hence next broadcast) this cycle
//   grant                : one-hot combinational grant
//   cdb_valid/tag/data/src : registered broadcast, one cycle after grant
// Build option: CDB_ARB_RR_EN defined selects round-robin; undefined selects fixed
// priority with unit 0 highest.
module cdb_arbiter
  import dispatcher_pkg::*;
#(
  parameter int N_REQ  = dispatcher_pkg::N_REQ,
  parameter int TAG_W  = dispatcher_pkg::TAG_W,
  parameter int DATA_W = dispatcher_pkg::DATA_W,
  parameter int IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*TAG_W-1:0]   req_tag,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic                     flush,
  output logic [N_REQ-1:0]         grant,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [IW-1:0]            cdb_src
);

  logic [N_REQ-1:0] pick_req;
  logic [IW-1:0]    start;
  logic [IW-1:0]    win;
  logic             granted;

  // Gating the request vector with rst keeps grant at zero during reset,
  // so no unit believes its result was consumed while the broadcast is held off.
  assign pick_req = req_valid & {N_REQ{rst & ~flush}};
  assign granted  = |grant;

`ifdef CDB_ARB_RR_EN
  logic [IW-1:0] ptr;

  assign start = ptr;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (granted) begin
      ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end
`else
  assign start = '0;
`endif

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (pick_req),
    .start (start),
    .gnt   (grant),
    .idx   (win)
  );

  // Payload fields hold their last value when nothing is granted; only valid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      cdb_valid <= granted;
      if (granted) begin
        cdb_tag  <= req_tag[win*TAG_W +: TAG_W];
        cdb_data <= req_data[win*DATA_W +: DATA_W];
        cdb_src  <= win;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter.
// Expectations follow the build option: CDB_ARB_RR_EN defined -> round-robin,
// undefined -> fixed priority with unit 0 highest.
module tb_cdb_arbiter;
  import dispatcher_pkg::*;

  localparam int IW = $clog2(N_REQ);

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    flush;
  logic [N_REQ-1:0]        grant;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [IW-1:0]           cdb_src;

  int n_checks;
  int n_errors;

  // Fixed per-unit payloads; unit 2 carries the reset-test result.
  logic [TAG_W-1:0]  unit_tag  [N_REQ];
  logic [DATA_W-1:0] unit_data [N_REQ];

`ifdef CDB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .flush     (flush),
    .grant     (grant),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bcast(input string tag, input int src);
    check({tag, ".valid"}, 64'(cdb_valid), 64'd1);
    check({tag, ".src"},   64'(cdb_src),   64'(src));
    check({tag, ".tag"},   64'(cdb_tag),   64'(unit_tag[src]));
    check({tag, ".data"},  64'(cdb_data),  64'(unit_data[src]));
  endtask

  initial begin
    logic [N_REQ-1:0] exp_g;
    n_checks = 0;
    n_errors = 0;

    unit_tag[0] = 6'h10;  unit_data[0] = 32'h1111_0000;
    unit_tag[1] = 6'h21;  unit_data[1] = 32'h2222_0001;
    unit_tag[2] = 6'h15;  unit_data[2] = 32'hDEAD_BEEF;
    unit_tag[3] = 6'h33;  unit_data[3] = 32'h4444_0003;
    for (int i = 0; i < N_REQ; i++) begin
      req_tag[i*TAG_W +: TAG_W]    = unit_tag[i];
      req_data[i*DATA_W +: DATA_W] = unit_data[i];
    end

    // Reset with every unit requesting: nothing granted, nothing broadcast.
    rst = 1'b0;
    flush = 1'b0;
    req_valid = 4'b1111;
    #3;
    check("rst.grant", 64'(grant), 64'd0);
    check("rst.valid", 64'(cdb_valid), 64'd0);
    step();
    step();
    check("rst.grant_hold", 64'(grant), 64'd0);
    check("rst.valid_hold", 64'(cdb_valid), 64'd0);
    check("rst.tag", 64'(cdb_tag), 64'd0);
    check("rst.data", 64'(cdb_data), 64'd0);
    check("rst.src", 64'(cdb_src), 64'd0);

    // Release; only unit 2 requests.
    rst = 1'b1;
    req_valid = 4'b0100;
    #1;
    check("first.grant", 64'(grant), 64'b0100);
    step();
    check_bcast("first", 2);
    req_valid = 4'b0000;
    #1;
    check("idle.grant", 64'(grant), 64'd0);
    step();
    check("idle.valid", 64'(cdb_valid), 64'd0);
    check("idle.tag_hold", 64'(cdb_tag), 64'h15);
    check("idle.src_hold", 64'(cdb_src), 64'd2);

    // Wrap: unit 3 alone (ptr wraps to 0), then units 1 and 3 together.
    req_valid = 4'b1000;
    #1;
    check("wrap.g3", 64'(grant), 64'b1000);
    step();
    check_bcast("wrap.b3", 3);
    req_valid = 4'b1010;
    #1;
    check("wrap.g1", 64'(grant), 64'b0010);
    step();
    check_bcast("wrap.b1", 1);
    req_valid = 4'b1000;
    #1;
    check("wrap.g3b", 64'(grant), 64'b1000);
    step();
    check_bcast("wrap.b3b", 3);

    // All four request continuously starting from ptr=0.
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      exp_g = RR ? N_REQ'(1) << (c % N_REQ) : N_REQ'(1);
      #1;
      check($sformatf("all.grant%0d", c), 64'(grant), 64'(exp_g));
      step();
      check_bcast($sformatf("all.b%0d", c), RR ? c % N_REQ : 0);
    end
    // Round-robin ptr is now 1; fixed priority has no ptr.

    // Flush holds off grant and broadcast; requests stay pending.
    req_valid = 4'b1010;
    flush = 1'b1;
    #1;
    check("flush.grant", 64'(grant), 64'd0);
    step();
    check("flush.valid", 64'(cdb_valid), 64'd0);
    flush = 1'b0;
    #1;
    check("unflush.grant", 64'(grant), 64'b0010);
    step();
    check_bcast("unflush", 1);

    // Round-robin ptr=2 picks unit 2; fixed picks unit 0. Then unit 3 alone.
    req_valid = 4'b0111;
    #1;
    check("low3.grant", 64'(grant), RR ? 64'b0100 : 64'b0001);
    step();
    check_bcast("low3", RR ? 2 : 0);
    req_valid = 4'b1000;
    #1;
    check("only3.grant", 64'(grant), 64'b1000);
    step();
    check_bcast("only3", 3);

    // Async reset mid-stream: grant unit 0 (ptr -> 1 in RR), then pull rst between edges.
    req_valid = 4'b0001;
    step();
    check_bcast("pre_rst", 0);
    #2;
    rst = 1'b0;
    #1;
    check("arst.valid", 64'(cdb_valid), 64'd0);
    check("arst.grant", 64'(grant), 64'd0);
    check("arst.src", 64'(cdb_src), 64'd0);
    step();
    rst = 1'b1;
    req_valid = 4'b0011;
    #1;
    check("post_rst.grant", 64'(grant), 64'b0001);
    step();
    check_bcast("post_rst", 0);

    req_valid = 4'b0000;
    step();
    check("end.valid", 64'(cdb_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
